// File: rtl/spi_addr_controller.sv
// spi_addr_controller: SPI front-end for one daisy-chained ASIC: deserializes frames, strobes the header address, runs chain enumeration.
//   iCLK, RSTin (async, active-low)         system clock / reset
//   sclk_local, scsn_local, mosi_local      raw SPI pins, asynchronous to iCLK
//   ID_in / ID_out                          enumeration token from previous / to next ASIC
//   currentSPIAddr, frame_write             header of the current frame, valid with address_strobe
//   rx_byte, rx_byte_valid                  last complete data byte and its one-cycle pulse
//   setSPIAddr, addr_valid                  unique address captured during enumeration
module spi_addr_controller #(
  parameter logic [7:0] CMD_SET_ADDR = 8'h5A,
  parameter logic [6:0] GLOBAL_ADDR  = 7'h7F
) (
  input  logic       iCLK,
  input  logic       RSTin,
  input  logic       sclk_local,
  input  logic       scsn_local,
  input  logic       mosi_local,
  input  logic       ID_in,
  output logic [6:0] currentSPIAddr,
  output logic       frame_write,
  output logic       address_strobe,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [6:0] setSPIAddr,
  output logic       addr_valid,
  output logic       ID_out
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
  typedef enum logic [1:0] {EN_WAIT, EN_CMD, EN_ARMED, EN_DONE} en_t;
  state_t     r_state;
  en_t        r_en;
  logic [1:0] r_sclk_sync, r_scsn_sync, r_mosi_sync, r_id_sync;
  logic       r_sclk_d;
  logic [2:0] r_cnt;
  logic [6:0] r_shift;
  logic       w_sclk_s, w_scsn_s, w_mosi_s, w_id_s, w_rise;
  logic [7:0] w_byte;
  assign w_sclk_s = r_sclk_sync[1];
  assign w_scsn_s = r_scsn_sync[1];
  assign w_mosi_s = r_mosi_sync[1];
  assign w_id_s   = r_id_sync[1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_byte   = {r_shift, w_mosi_s};
  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      r_sclk_sync    <= '0;
      r_scsn_sync    <= 2'b11;
      r_mosi_sync    <= '0;
      r_id_sync      <= '0;
      r_sclk_d       <= 1'b0;
      r_state        <= S_IDLE;
      r_en           <= EN_WAIT;
      r_cnt          <= '0;
      r_shift        <= '0;
      currentSPIAddr <= '0;
      frame_write    <= 1'b0;
      address_strobe <= 1'b0;
      rx_byte        <= '0;
      rx_byte_valid  <= 1'b0;
      setSPIAddr     <= '0;
      addr_valid     <= 1'b0;
      ID_out         <= 1'b0;
    end else begin
      r_sclk_sync    <= {r_sclk_sync[0], sclk_local};
      r_scsn_sync    <= {r_scsn_sync[0], scsn_local};
      r_mosi_sync    <= {r_mosi_sync[0], mosi_local};
      r_id_sync      <= {r_id_sync[0], ID_in};
      r_sclk_d       <= w_sclk_s;
      address_strobe <= 1'b0;
      rx_byte_valid  <= 1'b0;
      // chip select dominates a coincident SCLK rise: the bit is dropped
      if (w_scsn_s) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        if (r_en == EN_DONE) ID_out <= 1'b1;
        else r_en <= EN_WAIT;
      end else if (r_state == S_IDLE) begin
        r_state <= S_HDR;
        r_cnt   <= '0;
      end else if (w_rise) begin
        r_shift <= w_byte[6:0];
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          if (r_state == S_HDR) begin
            currentSPIAddr <= w_byte[6:0];
            frame_write    <= w_byte[7];
            address_strobe <= 1'b1;
            r_state        <= S_DATA;
            // token is sampled only here, so a later drop of ID_in cannot abort the frame
            if (r_en == EN_WAIT && w_byte == {1'b1, GLOBAL_ADDR} && w_id_s && !addr_valid) r_en <= EN_CMD;
          end else begin
            rx_byte       <= w_byte;
            rx_byte_valid <= 1'b1;
            if (r_en == EN_CMD) r_en <= (w_byte == CMD_SET_ADDR) ? EN_ARMED : EN_WAIT;
            else if (r_en == EN_ARMED) begin
              if (w_byte[6:0] != GLOBAL_ADDR) begin
                setSPIAddr <= w_byte[6:0];
                addr_valid <= 1'b1;
                r_en       <= EN_DONE;
              end else r_en <= EN_WAIT;
            end
          end
        end
      end
    end
  end
endmodule
